// File: rtl/axis_slave_fifo_if.sv
// AXI-Stream slave beat channel plus the local first-word-fall-through pop port.
// The FIFO uses the slave modport; whoever feeds the stream and pops uses master.
interface axis_slave_fifo_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  axis_tvalid;
  logic                  axis_tready;
  logic [DATA_WIDTH-1:0] axis_tdata;
  logic                  may_pop;
  logic                  pop;
  logic [DATA_WIDTH-1:0] data;

  modport slave (
    input  axis_tvalid, axis_tdata, pop,
    output axis_tready, may_pop, data
  );

  modport master (
    output axis_tvalid, axis_tdata, pop,
    input  axis_tready, may_pop, data
  );
endinterface

// File: rtl/axis_slave_fifo.sv
// AXIS-to-FWFT circular buffer: accepted beat is at the head one cycle later, pop advances next cycle.
// tready drops only at count==DEPTH and comes only from registered count (a pop reopens it a cycle later).
module axis_slave_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  axis_slave_fifo_if.slave           bus,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  underflow_q, underflow_d;
  logic                  acc, rem;

  assign bus.axis_tready = (count_q != CW'(DEPTH));
  assign bus.may_pop     = (count_q != '0);
  assign bus.data        = mem_q[rd_ptr_q];
  assign count           = count_q;
  assign underflow       = underflow_q;

  always_comb begin
    acc         = bus.axis_tvalid && bus.axis_tready;
    rem         = bus.pop && bus.may_pop;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    underflow_d = underflow_q;

    if (acc) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (rem) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    // Separate occupancy counter keeps full and empty distinct when the pointers meet.
    case ({acc, rem})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (bus.pop && !bus.may_pop) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is never cleared; a beat offered during reset must not land in it.
  always_ff @(posedge clk) begin
    if (acc && !rst) begin
      mem_q[wr_ptr_q] <= bus.axis_tdata;
    end
  end
endmodule

// File: tb/tb_axis_slave_fifo.sv
// Directed bench for axis_slave_fifo: scoreboard-checked sequences plus a hand-computed vector table.
module tb_axis_slave_fifo;
  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] count;
  logic       underflow;

  axis_slave_fifo_if #(.DATA_WIDTH(DW)) bus ();

  axis_slave_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .count     (count),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  logic [DW-1:0] sb[$];
  logic          uf_m;

  typedef struct {
    logic          r, tv;
    logic [DW-1:0] td;
    logic          pp;
    logic          e_rdy, e_mp, e_chk;
    logic [DW-1:0] e_dat;
    logic [4:0]    e_cnt;
    logic          e_uf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic tv, input logic [DW-1:0] td, input logic pp,
                              input logic e_rdy, input logic e_mp, input logic e_chk,
                              input logic [DW-1:0] e_dat, input logic [4:0] e_cnt, input logic e_uf);
    vec_t v;
    v.r = r; v.tv = tv; v.td = td; v.pp = pp;
    v.e_rdy = e_rdy; v.e_mp = e_mp; v.e_chk = e_chk;
    v.e_dat = e_dat; v.e_cnt = e_cnt; v.e_uf = e_uf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs at negedge, compare registered outputs to the model, advance model.
  task automatic step(input logic r, input logic tv, input logic [DW-1:0] td, input logic pp,
                      output logic accepted);
    logic full, empty;
    @(negedge clk);
    rst             = r;
    bus.axis_tvalid = tv;
    bus.axis_tdata  = td;
    bus.pop         = pp;
    full  = (sb.size() == DEPTH);
    empty = (sb.size() == 0);
    n_vec++;
    chk("tready",    {31'd0, bus.axis_tready}, {31'd0, !full});
    chk("may_pop",   {31'd0, bus.may_pop},     {31'd0, !empty});
    chk("count",     {27'd0, count},           sb.size());
    chk("underflow", {31'd0, underflow},       {31'd0, uf_m});
    if (!empty) chk("data", bus.data, sb[0]);
    accepted = 1'b0;
    if (r) begin
      sb.delete();
      uf_m = 1'b0;
    end else begin
      if (pp && empty) uf_m = 1'b1;
      if (pp && !empty) void'(sb.pop_front());
      if (tv && !full) begin
        sb.push_back(td);
        accepted = 1'b1;
      end
    end
  endtask

  task automatic drain();
    logic a;
    for (int i = 0; i < DEPTH + 2 && sb.size() != 0; i++) step(1'b0, 1'b0, '0, 1'b1, a);
    step(1'b0, 1'b0, '0, 1'b0, a);
  endtask

  initial begin
    logic          a;
    int            sent;
    int            cyc;
    logic [DW-1:0] beat;

    bus.axis_tvalid = 1'b0;
    bus.axis_tdata  = '0;
    bus.pop         = 1'b0;
    uf_m            = 1'b0;

    // Reset held 20 cycles, then 8 beats in and out in order.
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, '0, 1'b0, a);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, DW'(i * 10 + 5), 1'b0, a);
    step(1'b0, 1'b0, '0, 1'b0, a);
    chk("basic_count8", {27'd0, count}, 32'd8);
    drain();

    // Fill with a held tvalid: only 16 of 20 offers accepted, then one pop lets the 17th in.
    beat = 32'd1000;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, beat, 1'b0, a);
      if (a) beat++;
    end
    chk("fill_accepted", beat, 32'd1016);
    step(1'b0, 1'b1, beat, 1'b1, a);
    chk("full_pop_no_accept", {31'd0, a}, 32'd0);
    step(1'b0, 1'b1, beat, 1'b0, a);
    chk("beat17_accepted", {31'd0, a}, 32'd1);
    step(1'b0, 1'b0, '0, 1'b1, a);
    beat++;
    step(1'b0, 1'b1, beat, 1'b1, a);
    step(1'b0, 1'b0, '0, 1'b0, a);
    chk("depth_m1_count", {27'd0, count}, 32'd15);
    drain();

    // Random tvalid/pop, pop only issued while the model holds data.
    sent = 0;
    cyc  = 0;
    while (sent < 200 && cyc < 3000) begin
      step(1'b0, 1'($urandom_range(0, 1)), DW'(sent * 10 + 5),
           (sb.size() != 0) && 1'($urandom_range(0, 1)), a);
      if (a) sent++;
      cyc++;
    end
    chk("stress_all_sent", sent, 32'd200);
    drain();

    // Hand-computed table; starts from a fresh reset.
    step(1'b1, 1'b0, '0, 1'b0, a);
    vecs.push_back(mk(0, 1,  5, 0,  1, 0, 0,  0, 0, 0));
    vecs.push_back(mk(0, 1, 15, 0,  1, 1, 1,  5, 1, 0));
    vecs.push_back(mk(0, 1, 25, 1,  1, 1, 1,  5, 2, 0));
    vecs.push_back(mk(0, 0,  0, 1,  1, 1, 1, 15, 2, 0));
    vecs.push_back(mk(0, 0,  0, 0,  1, 1, 1, 25, 1, 0));
    vecs.push_back(mk(0, 1, 35, 1,  1, 1, 1, 25, 1, 0));
    vecs.push_back(mk(0, 0,  0, 0,  1, 1, 1, 35, 1, 0));
    vecs.push_back(mk(0, 0,  0, 1,  1, 1, 1, 35, 1, 0));
    vecs.push_back(mk(0, 0,  0, 1,  1, 0, 0,  0, 0, 0));
    vecs.push_back(mk(0, 1, 45, 0,  1, 0, 0,  0, 0, 1));
    vecs.push_back(mk(0, 0,  0, 0,  1, 1, 1, 45, 1, 1));
    vecs.push_back(mk(0, 0,  0, 1,  1, 1, 1, 45, 1, 1));
    vecs.push_back(mk(0, 1, 55, 0,  1, 0, 0,  0, 0, 1));
    vecs.push_back(mk(0, 1, 65, 0,  1, 1, 1, 55, 1, 1));
    vecs.push_back(mk(1, 1, 99, 0,  1, 1, 1, 55, 2, 1));
    vecs.push_back(mk(0, 0,  0, 0,  1, 0, 0,  0, 0, 0));
    vecs.push_back(mk(0, 1, 77, 0,  1, 0, 0,  0, 0, 0));
    vecs.push_back(mk(0, 0,  0, 1,  1, 1, 1, 77, 1, 0));
    vecs.push_back(mk(0, 0,  0, 0,  1, 0, 0,  0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst             = vecs[i].r;
      bus.axis_tvalid = vecs[i].tv;
      bus.axis_tdata  = vecs[i].td;
      bus.pop         = vecs[i].pp;
      n_vec++;
      chk($sformatf("vec%0d_tready", i),    {31'd0, bus.axis_tready}, {31'd0, vecs[i].e_rdy});
      chk($sformatf("vec%0d_may_pop", i),   {31'd0, bus.may_pop},     {31'd0, vecs[i].e_mp});
      chk($sformatf("vec%0d_count", i),     {27'd0, count},           {27'd0, vecs[i].e_cnt});
      chk($sformatf("vec%0d_underflow", i), {31'd0, underflow},       {31'd0, vecs[i].e_uf});
      if (vecs[i].e_chk) chk($sformatf("vec%0d_data", i), bus.data, vecs[i].e_dat);
    end

    @(negedge clk);
    rst             = 1'b0;
    bus.axis_tvalid = 1'b0;
    bus.pop         = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
